// File: rtl/gcd_datapath.sv
// gcd_datapath: X/Y operand datapath for a subtractive-GCD controller with result capture
// Ports:
//   clock, reset_n            rising-edge clock, synchronous active-low reset
//   data_in                   operand bus, sampled on load commands
//   update_x/data_is_x        write X: load data_in (1) or X-Y (0)
//   update_y/data_is_y        write Y: load data_in (1) or Y-X (0)
//   done                      controller done level; first cycle of a run captures X
//   x_equal_y/x_greater_y     status flags from the current registers
//   result/result_valid       captured GCD and its valid flag
//   iter_count                saturating count of subtract cycles since the last X load
//   sub_error                 sticky flag: a subtract was blocked
module gcd_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             update_x,
    input  logic             data_is_x,
    input  logic             update_y,
    input  logic             data_is_y,
    input  logic             done,
    output logic             x_equal_y,
    output logic             x_greater_y,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [CNT_W-1:0] iter_count,
    output logic             sub_error
);
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rv_q, rv_d, err_q, err_d;
    logic             x_load, x_sub, y_sub, x_blk, y_blk, x_ok, y_ok, cap;
    always_comb begin
        x_load = update_x & data_is_x;
        x_sub  = update_x & ~data_is_x;
        y_sub  = update_y & ~data_is_y;
        // a subtract is refused on underflow or when the subtrahend is zero (no progress)
        x_blk  = x_sub & ((x_q < y_q) | (y_q == '0));
        y_blk  = y_sub & ((y_q < x_q) | (x_q == '0));
        x_ok   = x_sub & ~x_blk;
        y_ok   = y_sub & ~y_blk;
        cap    = done & ~rv_q & ~x_load;
        x_d    = x_load ? data_in : x_ok ? x_q - y_q : x_q;
        y_d    = (update_y & data_is_y) ? data_in : y_ok ? y_q - x_q : y_q;
        // an X load starts a new run, so it overrides counting and error flagging in its cycle
        cnt_d  = x_load ? '0 : ((x_ok | y_ok) & (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
        err_d  = x_load ? 1'b0 : (x_blk | y_blk) ? 1'b1 : err_q;
        res_d  = cap ? x_q : res_q;
        rv_d   = x_load ? 1'b0 : cap ? 1'b1 : rv_q;
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x_q   <= '0;
            y_q   <= '0;
            res_q <= '0;
            cnt_q <= '0;
            rv_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
            rv_q  <= rv_d;
            err_q <= err_d;
        end
    end
    assign x_equal_y    = (x_q == y_q);
    assign x_greater_y  = (x_q > y_q);
    assign result       = res_q;
    assign result_valid = rv_q;
    assign iter_count   = cnt_q;
    assign sub_error    = err_q;
endmodule

// File: tb/tb_gcd_datapath.sv
// tb_gcd_datapath: directed and random checks of gcd_datapath against a behavioural model
module tb_gcd_datapath;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0, update_x = 1'b0, data_is_x = 1'b0;
    logic       update_y = 1'b0, data_is_y = 1'b0, done = 1'b0;
    logic [7:0] data_in = '0;
    logic       eq8, gt8, rv8, err8, eq4, gt4, rv4, err4;
    logic [7:0] res8, res4, cnt8;
    logic [3:0] cnt4;
    int         mx = 0, my = 0, mres = 0, mrv = 0, mc8 = 0, mc4 = 0, merr = 0;
    int         errors = 0, checks = 0;
    bit         en = 1'b0;

    always #5 clock = ~clock;

    gcd_datapath #(.WIDTH(8), .CNT_W(8)) u8 (
        .clock(clock), .reset_n(reset_n), .data_in(data_in),
        .update_x(update_x), .data_is_x(data_is_x), .update_y(update_y), .data_is_y(data_is_y),
        .done(done), .x_equal_y(eq8), .x_greater_y(gt8), .result(res8),
        .result_valid(rv8), .iter_count(cnt8), .sub_error(err8));

    gcd_datapath #(.WIDTH(8), .CNT_W(4)) u4 (
        .clock(clock), .reset_n(reset_n), .data_in(data_in),
        .update_x(update_x), .data_is_x(data_is_x), .update_y(update_y), .data_is_y(data_is_y),
        .done(done), .x_equal_y(eq4), .x_greater_y(gt4), .result(res4),
        .result_valid(rv4), .iter_count(cnt4), .sub_error(err4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // one clock of stimulus; the model advances from the pre-edge state using the same command
    task automatic drive(input bit rn, input bit ux, input bit dx, input bit uy, input bit dy,
                         input bit dn, input logic [7:0] din);
        int nx, ny;
        bit xb, yb, xs, ys, xl;
        @(negedge clock);
        reset_n = rn; update_x = ux; data_is_x = dx; update_y = uy; data_is_y = dy;
        done = dn; data_in = din;
        @(posedge clock);
        if (!rn) begin
            mx = 0; my = 0; mres = 0; mrv = 0; mc8 = 0; mc4 = 0; merr = 0;
        end else begin
            xl = ux && dx;
            xs = ux && !dx;
            ys = uy && !dy;
            xb = xs && (mx < my || my == 0);
            yb = ys && (my < mx || mx == 0);
            nx = xl ? int'(din) : (xs && !xb) ? mx - my : mx;
            ny = (uy && dy) ? int'(din) : (ys && !yb) ? my - mx : my;
            if (xl) begin
                mc8 = 0; mc4 = 0; merr = 0; mrv = 0;
            end else begin
                if ((xs && !xb) || (ys && !yb)) begin
                    mc8 = (mc8 < 255) ? mc8 + 1 : 255;
                    mc4 = (mc4 < 15) ? mc4 + 1 : 15;
                end
                if (xb || yb) merr = 1;
                if (dn && mrv == 0) begin
                    mres = mx; mrv = 1;
                end
            end
            mx = nx; my = ny;
        end
    endtask

    task automatic idle();     drive(1, 0, 0, 0, 0, 0, 8'd0); endtask
    task automatic sub_x();    drive(1, 1, 0, 0, 0, 0, 8'd0); endtask
    task automatic sub_y();    drive(1, 0, 0, 1, 0, 0, 8'd0); endtask
    task automatic fin();      drive(1, 0, 0, 0, 0, 1, 8'd0); endtask
    task automatic load_x(input logic [7:0] v); drive(1, 1, 1, 0, 0, 0, v); endtask
    task automatic load_y(input logic [7:0] v); drive(1, 0, 0, 1, 1, 0, v); endtask

    task automatic run_gcd(input logic [7:0] a, input logic [7:0] b);
        load_x(a);
        load_y(b);
        for (int i = 0; i < 400 && mx != my; i++)
            if (mx > my) sub_x(); else sub_y();
        fin();
    endtask

    always @(negedge clock) begin
        if (en) begin
            chk("eq8", eq8, mx == my);
            chk("gt8", gt8, mx > my);
            chk("res8", res8, mres);
            chk("rv8", rv8, mrv);
            chk("cnt8", cnt8, mc8);
            chk("err8", err8, merr);
            chk("eq4", eq4, mx == my);
            chk("gt4", gt4, mx > my);
            chk("res4", res4, mres);
            chk("rv4", rv4, mrv);
            chk("cnt4", cnt4, mc4);
            chk("err4", err4, merr);
        end
    end

    initial begin
        drive(0, 1, 1, 1, 1, 1, 8'd77);
        drive(0, 0, 0, 0, 0, 0, 8'd0);
        en = 1'b1;
        #1;
        chk("rst_eq", eq8, 1); chk("rst_gt", gt8, 0); chk("rst_res", res8, 0);
        chk("rst_rv", rv8, 0); chk("rst_cnt", cnt8, 0); chk("rst_err", err8, 0);

        load_x(48); load_y(18);
        sub_x(); #1; chk("s1_gt", gt8, 1);
        sub_x(); #1; chk("s2_gt", gt8, 0); chk("s2_eq", eq8, 0);
        sub_y(); #1; chk("s3_gt", gt8, 1);
        sub_x(); #1; chk("s4_eq", eq8, 1);
        fin(); #1;
        chk("g48_res", res8, 6); chk("g48_rv", rv8, 1); chk("g48_cnt", cnt8, 4);
        chk("g48_model_res", mres, 6); chk("g48_model_cnt", mc8, 4);

        load_x(20); load_y(7);
        drive(1, 1, 0, 1, 0, 0, 8'd0); #1;
        chk("both_err", err8, 1); chk("both_cnt", cnt8, 1); chk("both_gt", gt8, 1);
        chk("both_model_x", mx, 13);

        load_x(5); load_y(0);
        sub_x(); #1;
        chk("z_err", err8, 1); chk("z_cnt", cnt8, 0); chk("z_gt", gt8, 1);
        fin(); #1; chk("z_res", res8, 5); chk("z_rv", rv8, 1);
        load_x(9); #1;
        chk("lx_err", err8, 0); chk("lx_cnt", cnt8, 0); chk("lx_rv", rv8, 0); chk("lx_res", res8, 5);

        run_gcd(255, 1); #1;
        chk("sat_cnt4", cnt4, 15); chk("sat_cnt8", cnt8, 254);
        chk("sat_res4", res4, 1); chk("sat_rv4", rv4, 1);

        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0, 1, 8'd0);
        #1; chk("hold_res", res8, 1); chk("hold_rv", rv8, 1);

        load_x(30); load_y(18);
        drive(0, 1, 0, 0, 0, 1, 8'd0); #1;
        chk("mr_eq", eq8, 1); chk("mr_gt", gt8, 0); chk("mr_res", res8, 0);
        chk("mr_rv", rv8, 0); chk("mr_cnt", cnt8, 0); chk("mr_err", err8, 0);
        run_gcd(14, 21); #1;
        chk("g14_res", res8, 7); chk("g14_rv", rv8, 1); chk("g14_cnt", cnt8, 2);

        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            drive($urandom_range(0, 50) != 0, 1'($urandom), ($urandom_range(0, 3) == 0),
                  1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), d);
        end
        for (int k = 0; k < 20; k++) run_gcd(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)));
        idle();
        @(negedge clock);
        en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
